sfx_player: RTL and testbench
=============================

# sfx_player

Sound-effect sequencer and DAC driver that sits on both sides of the 3-bank audio sample ROM. It turns single-cycle game-event requests (jump, dead, win) into a paced address/select stream for the ROM. It also accounts for the ROM's 2-cycle read latency, latches each returned 8-bit unsigned sample, and drives a PWM audio pin. Higher-priority effects preempt lower ones; idle output is mid-scale silence.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- SAMPLE_HZ, 16_000, playback rate; DIV = CLK_HZ/SAMPLE_HZ (integer, ≥ 4)
- LEN_JUMP, 16_000, jump sample count (1..131072)
- LEN_DEAD, 32_000, dead sample count
- LEN_WIN, 64_000, win sample count
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- play_jump / play_dead / play_win  in  1 each  single-cycle request pulses
- rom_addr  out  17  ROM sample address
- rom_select  out  2  ROM bank: 00 none, 01 jump, 10 dead, 11 win
- rom_data  in  8  ROM output; valid 2 edges after addr/select change
- busy  out  1  effect in progress
- done  out  1  one-cycle pulse when an effect finishes naturally
- sample  out  8  current held sample
- pwm_out  out  1  PWM audio output

## Operation
- Reset values: rom_addr=0, rom_select=00, busy=0, done=0, sample=8'h80, pwm_out=0, state=IDLE, tick divider=0, PWM counter=0.
- Priority is win > dead > jump. With simultaneous requests, the highest priority is taken.
- States:
  - IDLE: no effect playing. A request loads rom_select with the bank code and sets rom_addr=0, fetch count=0, busy=1. Next state is FETCH.
  - FETCH: lasts exactly 3 cycles. On the 3rd cycle edge, sample<=rom_data. Next state is HOLD.
  - HOLD: waits for tick. On tick at rom_addr==LEN-1 (per bank): done=1 for one cycle, sample<=8'h80, rom_select<=00, rom_addr<=0, busy<=0. Next state is IDLE. Otherwise rom_addr<=rom_addr+1. Next state is FETCH.
- Preemption in FETCH or HOLD:
  - A request of strictly higher priority than the current bank restarts exactly as from IDLE (rom_addr=0, new select). done does not pulse.
  - Equal or lower priority requests are dropped.
- Tick:
  - Free-running divider counts 0..DIV-1.
  - tick is high for one cycle when the count is DIV-1.
  - A tick during FETCH is not lost. A pending flag is set and consumed on HOLD entry the next cycle.
  - The pending flag clears on restart or on IDLE.
- Address arithmetic is 17-bit unsigned and never wraps. End of effect is detected by compare, not overflow.
- PWM:
  - 8-bit free-running counter.
  - pwm_out = (pwm_cnt < sample), registered.
  - sample=8'h80 gives a 50% duty cycle.

## Timing
- Request sampled at edge E0. rom_select/rom_addr change at E0. sample updates at E0+3.
- Address step: new rom_addr at the tick edge T. sample updates at T+3.
- Sample period equals DIV cycles while ROM latency ≤ DIV-2. The parameter floor DIV≥4 guarantees this.
- done asserts the cycle after the final tick edge and lasts 1 cycle. busy falls on the same edge.
- pwm_out lags sample by 1 cycle. PWM period is 256 cycles.
- Reset mid-effect: all outputs return to reset values immediately (asynchronous). No done pulse.

## Structure
- Package sfx_pkg:
  - sfx_e enum (SFX_NONE=2'b00, SFX_JUMP=2'b01, SFX_DEAD=2'b10, SFX_WIN=2'b11)
  - state_e (IDLE, FETCH, HOLD)
  - ADDR_W=17, ROM_LAT=2
  - priority function prio(sfx_e)
- One sub-module: sample_pwm (clk, reset, sample[7:0] → pwm_out), holding the 8-bit counter and compare.

## Test plan
Bench parameters: CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), LEN_*=4. ROM model has 2-cycle latency and returns {bank,addr[5:0]}.
- Reset → sample=0x80, rom_select=00, busy=0; pwm_out high 128 of 256 cycles.
- play_jump at E0:
  - rom_select=01 at E0; sample=0x40 at E0+3.
  - Addresses 0,1,2,3, each 10 cycles apart; samples 0x40..0x43.
  - done pulses once after addr 3; busy falls; sample=0x80.
- play_jump and play_win in the same cycle → rom_select=11 only; jump never plays.
- play_win during jump addr 2 → rom_select=11, rom_addr=0 at the request edge; no done for jump; win plays 4 samples then done.
- play_jump during win → ignored; win address sequence is unchanged.
- reset asserted mid-FETCH of dead → immediate reset values. A subsequent play_dead restarts at addr 0.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect sequencer.
// Bank codes double as the ROM select encoding.
package sfx_pkg;

  typedef enum logic [1:0] {
    SFX_NONE = 2'b00,
    SFX_JUMP = 2'b01,
    SFX_DEAD = 2'b10,
    SFX_WIN  = 2'b11
  } sfx_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned ROM_LAT = 2;

  // Higher value wins; SFX_NONE ranks below every real effect.
  function automatic logic [1:0] prio(input sfx_e s);
    logic [1:0] p;
    case (s)
      SFX_WIN:  p = 2'd3;
      SFX_DEAD: p = 2'd2;
      SFX_JUMP: p = 2'd1;
      default:  p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sfx_player_pwm.sv
// 8-bit free-running PWM: output is high while the counter is below the held sample.
module sample_pwm (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  output logic       pwm_out
);

  logic [7:0] cnt_q, cnt_d;
  logic       pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    pwm_d = (cnt_q < sample);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/sfx_player.sv
// Sound-effect sequencer: paces ROM reads at SAMPLE_HZ, latches returned samples
// after the ROM latency, and feeds the PWM stage. Higher-priority requests preempt.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 16_000,
  parameter int unsigned LEN_JUMP  = 16_000,
  parameter int unsigned LEN_DEAD  = 32_000,
  parameter int unsigned LEN_WIN   = 64_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_jump,
  input  logic                play_dead,
  input  logic                play_win,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [1:0]          rom_select,
  input  logic [7:0]          rom_data,
  output logic                busy,
  output logic                done,
  output logic [7:0]          sample,
  output logic                pwm_out
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(DIV - 1);
  localparam logic [1:0]       FETCH_LAST = 2'(ROM_LAT);

  state_e              state_q, state_d;
  sfx_e                sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic                pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          sample_q, sample_d;
  logic [DIV_W-1:0]    div_q, div_d;

  sfx_e                req_sfx;
  logic                tick;
  logic                start;
  logic [ADDR_W-1:0]   last_addr;

  always_comb begin
    if (play_win)       req_sfx = SFX_WIN;
    else if (play_dead) req_sfx = SFX_DEAD;
    else if (play_jump) req_sfx = SFX_JUMP;
    else                req_sfx = SFX_NONE;
  end

  // sel_q is SFX_NONE when idle, so one compare covers both start and preemption.
  assign start = (prio(req_sfx) > prio(sel_q));
  assign tick  = (div_q == DIV_MAX);

  always_comb begin
    case (sel_q)
      SFX_JUMP: last_addr = ADDR_W'(LEN_JUMP - 1);
      SFX_DEAD: last_addr = ADDR_W'(LEN_DEAD - 1);
      SFX_WIN:  last_addr = ADDR_W'(LEN_WIN - 1);
      default:  last_addr = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sample_d = sample_q;
    div_d    = tick ? '0 : div_q + DIV_W'(1);

    if (start) begin
      sel_d   = req_sfx;
      addr_d  = '0;
      fcnt_d  = 2'd0;
      pend_d  = 1'b0;
      busy_d  = 1'b1;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          pend_d = 1'b0;
        end
        FETCH: begin
          // Remember a tick that lands mid-fetch so the step is not skipped.
          if (tick) pend_d = 1'b1;
          if (fcnt_q == FETCH_LAST) begin
            sample_d = rom_data;
            state_d  = HOLD;
          end else begin
            fcnt_d = fcnt_q + 2'd1;
          end
        end
        HOLD: begin
          if (tick || pend_q) begin
            pend_d = 1'b0;
            if (addr_q == last_addr) begin
              done_d   = 1'b1;
              sample_d = 8'h80;
              sel_d    = SFX_NONE;
              addr_d   = '0;
              busy_d   = 1'b0;
              state_d  = IDLE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              fcnt_d  = 2'd0;
              state_d = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= SFX_NONE;
      addr_q   <= '0;
      fcnt_q   <= 2'd0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= 8'h80;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      fcnt_q   <= fcnt_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      div_q    <= div_d;
    end
  end

  assign rom_addr   = addr_q;
  assign rom_select = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample     = sample_q;

  sample_pwm u_pwm (
    .clk     (clk),
    .reset   (reset),
    .sample  (sample_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_sfx_player.sv
// Scoreboard bench for sfx_player: stimulus pushes expected address, sample and done
// events; a negedge monitor pops and compares whenever the DUT output changes.
module tb_sfx_player;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play_jump = 1'b0, play_dead = 1'b0, play_win = 1'b0;
  logic [16:0] rom_addr;
  logic [1:0]  rom_select;
  logic [7:0]  rom_data;
  logic        busy, done, pwm_out;
  logic [7:0]  sample;
  logic [7:0]  rom_d1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [18:0] q_sa[$];
  logic [7:0]  q_smp[$];
  logic [1:0]  q_done[$];

  sfx_player #(
    .CLK_HZ   (1000),
    .SAMPLE_HZ(100),
    .LEN_JUMP (4),
    .LEN_DEAD (4),
    .LEN_WIN  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_jump  (play_jump),
    .play_dead  (play_dead),
    .play_win   (play_win),
    .rom_addr   (rom_addr),
    .rom_select (rom_select),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .sample     (sample),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage ROM returning {bank, addr[5:0]}.
  always @(posedge clk) begin
    rom_d1   <= {rom_select, rom_addr[5:0]};
    rom_data <= rom_d1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  task automatic push_effect(input logic [1:0] bank, input int first, input int last);
    for (int a = first; a <= last; a++) q_sa.push_back({bank, 17'(a)});
  endtask

  task automatic push_samples(input logic [1:0] bank, input int first, input int last);
    for (int a = first; a <= last; a++) q_smp.push_back({bank, 6'(a)});
  endtask

  task automatic push_end(input logic [1:0] bank);
    q_sa.push_back(19'd0);
    q_smp.push_back(8'h80);
    q_done.push_back(bank);
  endtask

  // Called at a negedge; inputs are held for exactly one rising edge.
  task automatic pulse(input logic j, input logic d, input logic w);
    play_jump = j; play_dead = d; play_win = w;
    @(negedge clk);
    play_jump = 1'b0; play_dead = 1'b0; play_win = 1'b0;
  endtask

  task automatic wait_sa(input logic [1:0] s, input logic [16:0] a);
    int k;
    for (k = 0; k < 200; k++) begin
      if (rom_select == s && rom_addr == a) break;
      @(negedge clk);
    end
    if (k == 200) fail_now("wait_sa");
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (k == 300) fail_now("wait_idle");
    repeat (3) @(negedge clk);
  endtask

  // Monitor
  logic [18:0] prev_sa, cur_sa, exp_sa;
  logic [7:0]  prev_smp, exp_smp;
  logic [1:0]  prev_sel, exp_bank;
  logic        prev_done;
  int          t_addr;

  initial begin
    wait (mon_en);
    prev_sa   = 19'd0;
    prev_smp  = 8'h80;
    prev_sel  = 2'b00;
    prev_done = 1'b0;
    t_addr    = 0;
    forever begin
      @(negedge clk);
      cur_sa = {rom_select, rom_addr};
      if (cur_sa !== prev_sa) begin
        if (q_sa.size() == 0) chk("sa_unexpected", cur_sa, prev_sa);
        else begin
          exp_sa = q_sa.pop_front();
          chk("sel_addr", cur_sa, exp_sa);
          if (cur_sa[18:17] == prev_sa[18:17] && cur_sa[16:0] == prev_sa[16:0] + 17'd1
              && cur_sa[16:0] >= 17'd3)
            chk("addr_spacing", cyc - t_addr, 10);
        end
        t_addr = cyc;
      end
      if (sample !== prev_smp) begin
        if (q_smp.size() == 0) chk("sample_unexpected", sample, prev_smp);
        else begin
          exp_smp = q_smp.pop_front();
          chk("sample", sample, exp_smp);
          if (sample != 8'h80) chk("sample_latency", cyc - t_addr, 3);
        end
      end
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("done_busy", busy, 0);
        if (q_done.size() == 0) chk("done_unexpected", done, 0);
        else begin
          exp_bank = q_done.pop_front();
          chk("done_bank", prev_sel, exp_bank);
        end
      end
      prev_sa   = cur_sa;
      prev_smp  = sample;
      prev_sel  = rom_select;
      prev_done = done;
    end
  end

  initial begin
    int hi;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sample", sample, 8'h80);
    chk("rst_select", rom_select, 2'b00);
    chk("rst_addr", rom_addr, 17'd0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pwm", pwm_out, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk("pwm_duty", hi, 128);

    // Plain jump
    push_effect(2'b01, 0, 3); push_samples(2'b01, 0, 3); push_end(2'b01);
    pulse(1, 0, 0);
    chk("busy_start", busy, 1);
    chk("jump_select", rom_select, 2'b01);
    wait_idle();

    // Simultaneous jump + win: win only
    push_effect(2'b11, 0, 3); push_samples(2'b11, 0, 3); push_end(2'b11);
    pulse(1, 0, 1);
    chk("simul_select", rom_select, 2'b11);
    wait_idle();

    // Win preempts jump during address 2 fetch
    push_effect(2'b01, 0, 2); push_samples(2'b01, 0, 1);
    push_effect(2'b11, 0, 3); push_samples(2'b11, 0, 3); push_end(2'b11);
    pulse(1, 0, 0);
    wait_sa(2'b01, 17'd2);
    pulse(0, 0, 1);
    chk("preempt_addr", rom_addr, 17'd0);
    wait_idle();

    // Jump during win is dropped
    push_effect(2'b11, 0, 3); push_samples(2'b11, 0, 3); push_end(2'b11);
    pulse(0, 0, 1);
    wait_sa(2'b11, 17'd1);
    pulse(1, 0, 0);
    chk("drop_select", rom_select, 2'b11);
    wait_idle();

    // Reset mid-fetch of dead, then dead from the top
    q_sa.push_back({2'b10, 17'd0});
    q_sa.push_back(19'd0);
    pulse(0, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_select", rom_select, 2'b00);
    chk("mid_rst_addr", rom_addr, 17'd0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sample", sample, 8'h80);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    push_effect(2'b10, 0, 3); push_samples(2'b10, 1, 3); push_end(2'b10);
    pulse(0, 1, 0);
    chk("dead_select", rom_select, 2'b10);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("q_sa_empty", q_sa.size(), 0);
    chk("q_smp_empty", q_smp.size(), 0);
    chk("q_done_empty", q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
